ma_tree_sequencer: RTL and testbench
====================================

Name: ma_tree_sequencer

Overview:
Sequences one multiply-adder tree through a convolution job. The tree is a fixed-latency, non-stallable pipeline that reduces MA_TREE_SIZE products to one 32-bit sum per cycle. For each output the block issues chunks_per_output operand fetches, accumulates the tree sums, and pushes one final result per output into a credit-protected output FIFO with a valid/ready interface. It sits between the layer controller (start/done), the operand buffers (op_* fetch strobes) and the downstream result consumer.

Parameters:
PIPE_LATENCY, 5, cycles from operands at the tree input to a valid tree_sum.
OPERAND_LATENCY, 1, cycles from op_valid to operands presented at the tree input.
COUNT_W, 16, width of the output counter and index.
CHUNKS_W, 8, width of the chunk counter and index.
FIFO_DEPTH, 8, output FIFO entries (power of 2, ≥2).

Ports:
clock  in  1  system clock.
reset  in  1  synchronous, active-high reset.
start  in  1  job start pulse; sampled only in IDLE.
num_outputs  in  COUNT_W  outputs in the job; sampled with start.
chunks_per_output  in  CHUNKS_W  tree passes per output; sampled with start; 0 is treated as 1.
busy  out  1  job in progress.
done  out  1  one-cycle pulse when the job completes.
op_valid  out  1  operand fetch strobe; one tree pass issued this cycle.
op_index  out  COUNT_W  output index of the issued pass.
op_chunk  out  CHUNKS_W  chunk index of the issued pass.
tree_sum  in  32  tree result; valid L = OPERAND_LATENCY+PIPE_LATENCY cycles after the matching op_valid.
res_valid  out  1  output FIFO not empty.
res_data  out  32  FIFO head.
res_ready  in  1  consumer accepts res_data when res_valid && res_ready.

Behaviour:
- Reset (synchronous, active-high) is valid in any state, including mid-job:
  - FSM goes to IDLE; the FIFO is emptied; the tag pipe, credits, counters and accumulator are cleared.
  - Outputs reset to busy=0, done=0, op_valid=0, op_index=0, op_chunk=0, res_valid=0, res_data=0.
  - In-flight tree sums are discarded.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE→ISSUE on start with num_outputs≠0. Latch num_outputs and the effective chunk count; set busy=1.
  - IDLE→DONE on start with num_outputs=0; nothing is issued.
  - start outside IDLE is ignored.
  - ISSUE: see the issue rules below. After the pass with op_index=num_outputs-1 and op_chunk=last, go to DRAIN.
  - DRAIN→DONE when the tag pipe is empty, the FIFO is empty and no credits are held.
  - DONE: done=1 for exactly one cycle, busy=0 in that cycle, then →IDLE. start in the DONE cycle is ignored.
- Issue rules (ISSUE state):
  - op_valid=1 unless op_chunk=0 and credits=FIFO_DEPTH. In that case stall: op_valid=0 and indices are held.
  - Chunk order: op_chunk counts 0..C-1, then op_index increments and op_chunk returns to 0.
  - Passes of one output are never interrupted by a stall, because credit is only checked at chunk 0.
- Credits:
  - Incremented when a chunk-0 pass issues.
  - Decremented on a FIFO pop.
  - Both in the same cycle: no change.
  - Credits never exceed FIFO_DEPTH, so a push can never overflow the FIFO.
- Tag pipe:
  - An L-stage shift register carries {valid, first, last} for each op_valid.
  - first = (op_chunk==0); last = (op_chunk==C-1).
- Accumulation at tag-pipe output (when valid):
  - acc_next = (first ? 0 : acc) + tree_sum, modulo 2^32. Signed and unsigned results are bit-identical.
  - If last: push acc_next to the FIFO; acc is don't-care afterwards.
  - If first and last are both set (C=1), push tree_sum directly.
- Output FIFO:
  - First-word-fall-through: res_valid = !empty, res_data = head.
  - Pop when res_valid && res_ready; push and pop in the same cycle are allowed, including when full.
  - res_data holds its value while res_valid && !res_ready.
- Latency: first result reaches res_valid at L+C cycles after the first op_valid (L pipe + C chunks − 1 + 1 FIFO write).
- Throughput: one tree pass per cycle when res_ready is held high.

Test Plan:
- num_outputs=3, C=1, L=6, res_ready=1, tree_sum=index+10:
  - 3 consecutive op_valid; results 10, 11, 12 in order.
  - done pulses once; busy falls in the same cycle.
- num_outputs=2, C=4, tree_sum=1,2,3,4,5,6,7,8:
  - res_data=10, then 26.
  - op_chunk sequence 0,1,2,3,0,1,2,3.
- Backpressure, num_outputs=20, C=1, res_ready=0:
  - Exactly 8 op_valid, then a stall; 8 entries held, no overflow.
  - Release res_ready: all 20 results arrive in order.
  - Never more than 8 credits held.
- Wrap: C=2, tree_sum=0xFFFFFFFF then 0x00000002 → result 0x00000001.
- Zero-length job: start with num_outputs=0 → no op_valid; done=1 one cycle later.
- Reset mid-job:
  - Assert reset during ISSUE with 3 results in the FIFO.
  - Next cycle: res_valid=0, busy=0, credits=0, no stale push from the tag pipe.
  - A new job runs correctly.
  - start asserted during ISSUE is ignored.

Source files
------------

// File: rtl/ma_tree_sequencer.sv
// Sequences a fixed-latency multiply-adder tree through a convolution job:
// issues operand fetches, accumulates tree sums per output, and queues results.
module ma_tree_sequencer #(
  parameter int unsigned PIPE_LATENCY    = 5,
  parameter int unsigned OPERAND_LATENCY = 1,
  parameter int unsigned COUNT_W         = 16,
  parameter int unsigned CHUNKS_W        = 8,
  parameter int unsigned FIFO_DEPTH      = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [COUNT_W-1:0]  num_outputs,
  input  logic [CHUNKS_W-1:0] chunks_per_output,
  output logic                busy,
  output logic                done,
  output logic                op_valid,
  output logic [COUNT_W-1:0]  op_index,
  output logic [CHUNKS_W-1:0] op_chunk,
  input  logic [31:0]         tree_sum,
  output logic                res_valid,
  output logic [31:0]         res_data,
  input  logic                res_ready
);

  localparam int unsigned L  = PIPE_LATENCY + OPERAND_LATENCY;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t              state;
  logic [COUNT_W-1:0]  num_lat;
  logic [CHUNKS_W-1:0] last_chunk;
  logic [CW-1:0]       credits;
  logic [CW-1:0]       credits_next;
  logic [L-1:0]        tag_valid;
  logic [L-1:0]        tag_first;
  logic [L-1:0]        tag_last;
  logic [31:0]         acc;
  logic [31:0]         acc_next;
  logic [31:0]         mem [FIFO_DEPTH];
  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;
  logic                empty;
  logic                push;
  logic                pop;
  logic                issue_first;
  logic                last_pass;
  logic                next_at_zero;
  logic [COUNT_W-1:0]  next_index;
  logic [CHUNKS_W-1:0] next_chunk;

  always_comb begin
    empty        = (wr_ptr == rd_ptr);
    pop          = !empty && res_ready;
    push         = tag_valid[L-1] && tag_last[L-1];
    acc_next     = (tag_first[L-1] ? '0 : acc) + tree_sum;
    issue_first  = op_valid && (op_chunk == '0);
    credits_next = credits + CW'(issue_first) - CW'(pop);
    last_pass    = (op_index == num_lat - COUNT_W'(1)) && (op_chunk == last_chunk);
    next_at_zero = (op_chunk == last_chunk);
    next_index   = next_at_zero ? op_index + COUNT_W'(1) : op_index;
    next_chunk   = next_at_zero ? '0 : op_chunk + CHUNKS_W'(1);
    res_valid    = !empty;
    res_data     = empty ? '0 : mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      op_valid   <= 1'b0;
      op_index   <= '0;
      op_chunk   <= '0;
      num_lat    <= '0;
      last_chunk <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (num_outputs == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state      <= ISSUE;
              busy       <= 1'b1;
              num_lat    <= num_outputs;
              last_chunk <= (chunks_per_output == '0) ? '0
                                                      : chunks_per_output - CHUNKS_W'(1);
              op_index   <= '0;
              op_chunk   <= '0;
              op_valid   <= (credits_next != CW'(FIFO_DEPTH));
            end
          end
        end
        ISSUE: begin
          // A stall is only ever entered at chunk 0, so an output's passes stay contiguous.
          if (op_valid && last_pass) begin
            state    <= DRAIN;
            op_valid <= 1'b0;
          end else if (op_valid) begin
            op_index <= next_index;
            op_chunk <= next_chunk;
            op_valid <= !(next_at_zero && (credits_next == CW'(FIFO_DEPTH)));
          end else begin
            op_valid <= (credits_next != CW'(FIFO_DEPTH));
          end
        end
        DRAIN: begin
          if ((tag_valid == '0) && empty && (credits == '0)) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      credits   <= '0;
      tag_valid <= '0;
      tag_first <= '0;
      tag_last  <= '0;
      acc       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      credits      <= credits_next;
      tag_valid[0] <= op_valid;
      tag_first[0] <= (op_chunk == '0);
      tag_last[0]  <= (op_chunk == last_chunk);
      for (int unsigned i = 1; i < L; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_first[i] <= tag_first[i-1];
        tag_last[i]  <= tag_last[i-1];
      end
      if (tag_valid[L-1]) acc <= acc_next;
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= acc_next;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: tb/tb_ma_tree_sequencer.sv
// Scoreboard bench for ma_tree_sequencer: a behavioural tree model feeds
// tree_sum, directed jobs queue hand-computed results, a monitor checks pops.
module tb_ma_tree_sequencer;
  localparam int L = 6;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_outputs = '0;
  logic [7:0]  chunks_per_output = '0;
  logic        busy, done, op_valid, res_valid, res_ready;
  logic [15:0] op_index;
  logic [7:0]  op_chunk;
  logic [31:0] tree_sum, res_data;

  ma_tree_sequencer #(.PIPE_LATENCY(5), .OPERAND_LATENCY(1), .COUNT_W(16),
                      .CHUNKS_W(8), .FIFO_DEPTH(8)) dut (
    .clock(clock), .reset(reset), .start(start), .num_outputs(num_outputs),
    .chunks_per_output(chunks_per_output), .busy(busy), .done(done),
    .op_valid(op_valid), .op_index(op_index), .op_chunk(op_chunk),
    .tree_sum(tree_sum), .res_valid(res_valid), .res_data(res_data),
    .res_ready(res_ready));

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int mode = 0;
  int cyc = 0;
  int op_count = 0;
  int done_count = 0;
  logic done_prev = 1'b0;
  logic stall_prev = 1'b0;
  logic [31:0] hold_data = '0;
  logic [31:0] expq[$];
  int log_cyc[$];
  int log_chunk[$];
  logic [31:0] tp [0:L];
  logic        tv [0:L];

  initial for (int i = 0; i <= L; i++) begin tp[i] = '0; tv[i] = 1'b0; end

  assign tree_sum = tv[L] ? tp[L] : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] tval(input int m, input int idx, input int ch);
    case (m)
      0: return 32'(idx + 10);
      1: return 32'(idx * 4 + ch + 1);
      2: return 32'(idx + 100);
      3: return (ch == 0) ? 32'hFFFF_FFFF : 32'h0000_0002;
      default: return 32'(idx * 3 + 7);
    endcase
  endfunction

  // Tree model, op log, done monitor and result scoreboard, all sampled mid-cycle.
  always @(negedge clock) begin
    cyc++;
    for (int i = L; i > 0; i--) begin tp[i] = tp[i-1]; tv[i] = tv[i-1]; end
    tv[0] = op_valid;
    tp[0] = tval(mode, int'(op_index), int'(op_chunk));
    if (op_valid) begin
      op_count++;
      log_cyc.push_back(cyc);
      log_chunk.push_back(int'(op_chunk));
    end
    if (done) begin
      done_count++;
      chk("done_busy", busy, 0);
      chk("done_width", done_prev, 0);
    end
    done_prev = done;
    if (stall_prev && res_valid) chk("res_hold", res_data, hold_data);
    if (res_valid && res_ready) begin
      if (expq.size() == 0) chk("unexpected_result", res_data, 32'hFFFF_FFFE);
      else chk("result", res_data, expq.pop_front());
    end
    stall_prev = res_valid && !res_ready;
    hold_data  = res_data;
  end

  task automatic start_job(input int n, input int c);
    @(posedge clock); #1;
    start = 1'b1; num_outputs = 16'(n); chunks_per_output = 8'(c);
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0 = done_count;
    int n = 0;
    while (done_count == d0 && n < budget) begin @(posedge clock); #1; n++; end
    if (done_count == d0) chk({name, "_timeout"}, 0, 1);
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    int ops0, d0;
    res_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_op_valid", op_valid, 0);
    chk("rst_op_index", op_index, 0);
    chk("rst_op_chunk", op_chunk, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    reset = 1'b0;

    // C=1, three outputs back to back
    mode = 0; log_cyc.delete(); log_chunk.delete();
    ops0 = op_count; d0 = done_count;
    expq.push_back(10); expq.push_back(11); expq.push_back(12);
    start_job(3, 1);
    chk("t1_busy", busy, 1);
    wait_done("t1", 200);
    chk("t1_ops", op_count - ops0, 3);
    chk("t1_done_once", done_count - d0, 1);
    chk("t1_consecutive", log_cyc.size() == 3 ? log_cyc[2] - log_cyc[0] : -1, 2);
    chk("t1_drained", expq.size(), 0);

    // C=4, chunk order and accumulation
    mode = 1; log_cyc.delete(); log_chunk.delete();
    expq.push_back(10); expq.push_back(26);
    start_job(2, 4);
    wait_done("t2", 200);
    chk("t2_ops", log_chunk.size(), 8);
    for (int i = 0; i < 8 && i < log_chunk.size(); i++)
      chk($sformatf("t2_chunk%0d", i), log_chunk[i], i % 4);
    chk("t2_drained", expq.size(), 0);

    // Backpressure: eight credits then stall; ignored restart mid-job
    mode = 2; res_ready = 1'b0; ops0 = op_count;
    for (int i = 0; i < 20; i++) expq.push_back(32'(i + 100));
    start_job(20, 1);
    repeat (30) @(posedge clock);
    #1;
    chk("t3_ops_stalled", op_count - ops0, 8);
    chk("t3_op_valid_low", op_valid, 0);
    chk("t3_res_valid", res_valid, 1);
    chk("t3_busy", busy, 1);
    start = 1'b1; num_outputs = 16'd1; chunks_per_output = 8'd1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    chk("t3_ops_still", op_count - ops0, 8);
    res_ready = 1'b1;
    wait_done("t3", 400);
    chk("t3_ops_total", op_count - ops0, 20);
    chk("t3_drained", expq.size(), 0);

    // Modulo-2^32 wrap across two chunks
    mode = 3;
    expq.push_back(32'h0000_0001);
    start_job(1, 2);
    wait_done("t4", 200);
    chk("t4_drained", expq.size(), 0);

    // chunks_per_output=0 behaves as 1
    mode = 0; ops0 = op_count;
    expq.push_back(10); expq.push_back(11);
    start_job(2, 0);
    wait_done("t5", 200);
    chk("t5_ops", op_count - ops0, 2);
    chk("t5_drained", expq.size(), 0);

    // Zero-length job
    ops0 = op_count;
    @(posedge clock); #1;
    start = 1'b1; num_outputs = '0; chunks_per_output = 8'd3;
    @(posedge clock); #1;
    start = 1'b0;
    chk("t6_done", done, 1);
    chk("t6_busy", busy, 0);
    @(posedge clock); #1;
    chk("t6_done_low", done, 0);
    repeat (3) @(posedge clock);
    #1;
    chk("t6_no_ops", op_count - ops0, 0);

    // Reset mid-job with results queued
    mode = 4; res_ready = 1'b0;
    for (int i = 0; i < 10; i++) expq.push_back(32'(i * 3 + 7));
    start_job(10, 1);
    begin
      int n = 0;
      while (!res_valid && n < 50) begin @(posedge clock); #1; n++; end
      chk("t7_res_valid_before", res_valid, 1);
    end
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    expq.delete();
    chk("t7_res_valid", res_valid, 0);
    chk("t7_busy", busy, 0);
    chk("t7_op_valid", op_valid, 0);
    chk("t7_res_data", res_data, 0);
    for (int i = 0; i < L + 3; i++) begin
      @(posedge clock); #1;
      chk("t7_no_stale", res_valid, 0);
    end
    mode = 0; res_ready = 1'b1; ops0 = op_count;
    expq.push_back(10); expq.push_back(11);
    start_job(2, 1);
    wait_done("t7", 200);
    chk("t7_ops", op_count - ops0, 2);
    chk("t7_drained", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d expected 0", 1);
    $fatal(1, "timeout");
  end
endmodule
